// File: rtl/nibbler_core_p.sv
// nibbler_core_p: parametrised two-phase (fetch/execute) accumulator core with a
// scratch register file, stalling valid/ready I/O ports and a HALT state.
module nibbler_core_p #(
  parameter int unsigned DW     = 4,
  parameter int unsigned AW     = 8,
  parameter int unsigned RDEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic [AW-1:0] pc_addr_o,
  input  logic [AW+3:0] instr_i,
  output logic [DW-1:0] acc_o,
  output logic          phase_o,
  output logic          carry_n_o,
  output logic          zero_n_o,
  output logic          halted_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o
);

  localparam int unsigned RW = $clog2(RDEPTH);

  localparam logic [1:0] StFetch = 2'd0;
  localparam logic [1:0] StExec  = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpHalt  = 4'h1;
  localparam logic [3:0] OpCompi = 4'h2;
  localparam logic [3:0] OpJc    = 4'h3;
  localparam logic [3:0] OpLit   = 4'h4;
  localparam logic [3:0] OpJz    = 4'h5;
  localparam logic [3:0] OpJnz   = 4'h6;
  localparam logic [3:0] OpJmp   = 4'h7;
  localparam logic [3:0] OpLd    = 4'h8;
  localparam logic [3:0] OpSt    = 4'h9;
  localparam logic [3:0] OpAddi  = 4'hA;
  localparam logic [3:0] OpAdd   = 4'hB;
  localparam logic [3:0] OpOut   = 4'hC;
  localparam logic [3:0] OpIn    = 4'hD;
  localparam logic [3:0] OpNori  = 4'hE;
  localparam logic [3:0] OpNor   = 4'hF;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          c_q, c_d;
  logic          z_q, z_d;
  logic [AW+3:0] ir_q, ir_d;
  logic [DW-1:0] rf_q [RDEPTH];

  logic [3:0]    op;
  logic [AW-1:0] fld;
  logic [DW-1:0] imm;
  logic [RW-1:0] ra;
  logic [DW-1:0] rf_rd;
  logic          is_exec;
  logic          stall;
  logic          rf_we;
  logic          acc_wr;
  logic          take;
  logic [DW:0]   sum;

  assign op      = ir_q[AW+3:AW];
  assign fld     = ir_q[AW-1:0];
  assign imm     = fld[DW-1:0];
  assign ra      = fld[RW-1:0];
  assign rf_rd   = rf_q[ra];
  assign is_exec = (state_q == StExec);
  // Handshake stalls only gate completion; valid/ready outputs depend on state alone.
  assign stall   = ((op == OpOut) && !out_ready_i) || ((op == OpIn) && !in_valid_i);
  assign rf_we   = is_exec && !stall && (op == OpSt);

  // Sequencer next-state: fetch latches IR, execute performs the op unless stalled.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    c_d     = c_q;
    z_d     = z_q;
    ir_d    = ir_q;
    acc_wr  = 1'b0;
    take    = 1'b0;
    sum     = '0;
    case (state_q)
      StFetch: begin
        ir_d    = instr_i;
        state_d = StExec;
      end
      StExec: begin
        if (!stall) begin
          state_d = StFetch;
          case (op)
            OpNop: ;
            OpHalt: state_d = StHalt;
            OpCompi: begin
              // Two's-complement subtract; carry set means acc >= imm.
              sum = {1'b0, acc_q} + {1'b0, ~imm} + (DW + 1)'(1);
              c_d = sum[DW];
              z_d = (sum[DW-1:0] == '0);
            end
            OpJc:  take = c_q;
            OpLit: begin
              acc_d  = imm;
              acc_wr = 1'b1;
            end
            OpJz:  take = z_q;
            OpJnz: take = !z_q;
            OpJmp: take = 1'b1;
            OpLd: begin
              acc_d  = rf_rd;
              acc_wr = 1'b1;
            end
            OpSt: ;
            OpAddi: begin
              sum          = {1'b0, acc_q} + {1'b0, imm};
              {c_d, acc_d} = sum;
              acc_wr       = 1'b1;
            end
            OpAdd: begin
              sum          = {1'b0, acc_q} + {1'b0, rf_rd};
              {c_d, acc_d} = sum;
              acc_wr       = 1'b1;
            end
            OpOut: ;
            OpIn: begin
              acc_d  = in_data_i;
              acc_wr = 1'b1;
            end
            OpNori: begin
              acc_d  = ~(acc_q | imm);
              acc_wr = 1'b1;
            end
            OpNor: begin
              acc_d  = ~(acc_q | rf_rd);
              acc_wr = 1'b1;
            end
          endcase
          if (acc_wr) z_d = (acc_d == '0);
          // HALT leaves the PC pointing at itself.
          if (op != OpHalt) pc_d = take ? fld : pc_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  // Architectural state with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFetch;
      pc_q    <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      z_q     <= z_d;
      ir_q    <= ir_d;
    end
  end

  // Scratch register file: deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (rf_we) rf_q[ra] <= acc_q;
  end

  assign pc_addr_o   = pc_q;
  assign acc_o       = acc_q;
  assign phase_o     = is_exec;
  assign carry_n_o   = ~c_q;
  assign zero_n_o    = ~z_q;
  assign halted_o    = (state_q == StHalt);
  assign out_data_o  = acc_q;
  assign out_valid_o = is_exec && (op == OpOut);
  assign in_ready_o  = is_exec && (op == OpIn);

endmodule

// File: tb/tb_nibbler_core_p.sv
// Self-checking bench for nibbler_core_p: directed program steps plus random
// instructions, compared against an instruction-level reference interpreter.
module tb_nibbler_core_p;

  localparam int DW     = 4;
  localparam int AW     = 8;
  localparam int RDEPTH = 4;
  localparam int MASK   = (1 << DW) - 1;
  localparam int PMASK  = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] pc_addr;
  logic [AW+3:0] instr;
  logic [DW-1:0] acc;
  logic          phase, carry_n, zero_n, halted;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;

  logic [AW+3:0] rom [1 << AW];
  assign instr = rom[pc_addr];

  nibbler_core_p #(.DW(DW), .AW(AW), .RDEPTH(RDEPTH)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pc_addr_o  (pc_addr),
    .instr_i    (instr),
    .acc_o      (acc),
    .phase_o    (phase),
    .carry_n_o  (carry_n),
    .zero_n_o   (zero_n),
    .halted_o   (halted),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference machine state
  int m_pc, m_acc, m_c, m_z, m_halt;
  int m_rf  [RDEPTH];
  bit m_rfv [RDEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_halt = 0;
  endtask

  // Whole-instruction semantics from the opcode table.
  task automatic model_step(input int op, input int f, input int inval);
    int imm, r, s, jump;
    imm  = f & MASK;
    r    = f % RDEPTH;
    jump = 0;
    case (op)
      1:  m_halt = 1;
      2:  begin m_c = (m_acc >= imm); m_z = (m_acc == imm); end
      3:  jump = m_c;
      4:  m_acc = imm;
      5:  jump = m_z;
      6:  jump = !m_z;
      7:  jump = 1;
      8:  m_acc = m_rf[r];
      9:  begin m_rf[r] = m_acc; m_rfv[r] = 1; end
      10: begin s = m_acc + imm; m_c = (s > MASK); m_acc = s & MASK; end
      11: begin s = m_acc + m_rf[r]; m_c = (s > MASK); m_acc = s & MASK; end
      13: m_acc = inval;
      14: m_acc = ~(m_acc | imm) & MASK;
      15: m_acc = ~(m_acc | m_rf[r]) & MASK;
      default: ;
    endcase
    if (op inside {4, 8, 10, 11, 13, 14, 15}) m_z = (m_acc == 0);
    if (op != 1) m_pc = jump ? f : (m_pc + 1) & PMASK;
  endtask

  task automatic check_state();
    chk("pc", 32'(pc_addr), 32'(m_pc));
    chk("acc", 32'(acc), 32'(m_acc));
    chk("carry_n", 32'(carry_n), 32'(!m_c));
    chk("zero_n", 32'(zero_n), 32'(!m_z));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("phase_fetch", 32'(phase), 32'd0);
    chk("out_data", 32'(out_data), 32'(m_acc));
  endtask

  // Runs one instruction from a fetch-phase negedge to the next fetch-phase negedge.
  task automatic do_instr(input int op, input int f, input int dly, input int inval);
    rom[m_pc] = {4'(op), 8'(f)};
    chk("fetch_pc", 32'(pc_addr), 32'(m_pc));
    chk("fetch_phase", 32'(phase), 32'd0);
    @(negedge clk);
    chk("exec_phase", 32'(phase), 32'd1);
    if (op == 12) begin
      for (int i = 0; i < dly; i++) begin
        chk("out_valid_stall", 32'(out_valid), 32'd1);
        chk("out_data_stall", 32'(out_data), 32'(m_acc));
        chk("pc_stall", 32'(pc_addr), 32'(m_pc));
        @(negedge clk);
      end
      chk("out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end else if (op == 13) begin
      in_data = DW'(~inval);
      for (int i = 0; i < dly; i++) begin
        chk("in_ready_stall", 32'(in_ready), 32'd1);
        chk("acc_stall", 32'(acc), 32'(m_acc));
        @(negedge clk);
      end
      chk("in_ready", 32'(in_ready), 32'd1);
      in_data  = DW'(inval);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end else begin
      chk("no_out_valid", 32'(out_valid), 32'd0);
      chk("no_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    model_step(op, f, inval);
    check_state();
  endtask

  task automatic reset_outputs_check();
    chk("rst_pc", 32'(pc_addr), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_carry_n", 32'(carry_n), 32'd1);
    chk("rst_zero_n", 32'(zero_n), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    int op, f;
    for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
    for (int i = 0; i < RDEPTH; i++) begin m_rf[i] = 0; m_rfv[i] = 0; end
    model_reset();

    // Reset
    repeat (2) @(negedge clk);
    reset_outputs_check();
    rst_n = 1'b1;

    // LIT 0, LIT 15, NORI 15, ADDI 1, COMPI 1
    do_instr(4, 0, 0, 0);
    do_instr(4, 15, 0, 0);
    do_instr(14, 15, 0, 0);
    chk("nori_acc", 32'(acc), 32'd0);
    chk("nori_zero_n", 32'(zero_n), 32'd0);
    do_instr(10, 1, 0, 0);
    chk("addi_acc", 32'(acc), 32'd1);
    do_instr(2, 1, 0, 0);
    chk("compi_carry_n", 32'(carry_n), 32'd0);
    chk("compi_zero_n", 32'(zero_n), 32'd0);

    // Carry wrap, JC taken, JNZ not taken
    do_instr(4, 15, 0, 0);
    do_instr(10, 1, 0, 0);
    chk("wrap_acc", 32'(acc), 32'd0);
    do_instr(3, 8'h40, 0, 0);
    chk("jc_taken", 32'(pc_addr), 32'h40);
    do_instr(6, 8'h20, 0, 0);
    chk("jnz_not_taken", 32'(pc_addr), 32'h41);

    // PC wrap and JMP
    do_instr(7, 8'hFF, 0, 0);
    do_instr(0, 0, 0, 0);
    chk("pc_wrap", 32'(pc_addr), 32'h00);
    do_instr(7, 8'h10, 0, 0);
    chk("jmp", 32'(pc_addr), 32'h10);

    // Register file
    do_instr(4, 9, 0, 0);
    do_instr(9, 2, 0, 0);
    do_instr(4, 0, 0, 0);
    do_instr(11, 2, 0, 0);
    chk("add_rf", 32'(acc), 32'd9);
    do_instr(15, 2, 0, 0);
    chk("nor_rf", 32'(acc), 32'd6);

    // I/O stalls
    do_instr(4, 5, 0, 0);
    do_instr(12, 0, 4, 0);
    do_instr(13, 0, 3, 10);
    chk("in_acc", 32'(acc), 32'hA);

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 15);
      f  = $urandom_range(0, PMASK);
      if (op == 1) op = 0;
      if ((op == 8 || op == 11 || op == 15) && !m_rfv[f % RDEPTH]) op = 9;
      do_instr(op, f, $urandom_range(0, 3), $urandom_range(0, MASK));
    end

    // Reset mid-OUT-stall
    rom[m_pc] = {4'hC, 8'h00};
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_outputs_check();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Restart at 0, then HALT at PC 3
    do_instr(4, 1, 0, 0);
    do_instr(4, 2, 0, 0);
    do_instr(4, 3, 0, 0);
    do_instr(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      rom[3] = 12'($urandom);
      @(negedge clk);
      chk("halt_pc", 32'(pc_addr), 32'd3);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_phase", 32'(phase), 32'd0);
      chk("halt_acc", 32'(acc), 32'd3);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
